bpred_btb: RTL and testbench
============================

# bpred_btb

Parametrised branch target buffer with per-entry saturating direction counters, replacing the single-entry predict-PC path in the next-PC logic. Looked up combinationally by the IF-stage word PC to produce a predicted next PC; trained at the clock edge by the branch/jump resolution in EX. Adds tag-checked multi-entry storage, configurable counter width and an optional gshare-style global history index, plus a saturating mispredict counter for performance measurement.

## Interface

- PC_W, 30, word-address PC width (byte address bits [1:0] dropped)
- IDX_W, 6, index width; ENTRIES = 2**IDX_W, direct-mapped
- CTR_W, 2, direction counter width (≥2)
- GHR_W, 4, global history width (1 ≤ GHR_W ≤ IDX_W); used only under BPRED_GHR_EN
- clk  in  1  clock, rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- pc  in  PC_W  IF-stage lookup PC
- pred_taken  out  1  predicted taken
- pred_pc  out  PC_W  predicted next PC
- pred_ghr  out  GHR_W  history used for this lookup (to be carried down the pipe)
- upd_valid  in  1  resolution valid this cycle
- upd_cond  in  1  1 = conditional branch, 0 = unconditional direct jump (j/jal)
- upd_pc  in  PC_W  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  PC_W  actual taken target
- upd_ghr  in  GHR_W  pred_ghr captured at this instruction's lookup
- upd_mispredict  in  1  pipeline flushed for this instruction
- mispredict_cnt  out  32  saturating mispredict count

## Operation

- Entry: valid, tag = pc[PC_W-1:IDX_W], target[PC_W], ctr[CTR_W]. Tag/target index ti = pc[IDX_W-1:0]; counter index ci = ti (or hashed, see Configuration).
- Lookup (combinational on pc): hit = valid[ti] && tag match. pred_taken = hit && ctr[ci][CTR_W-1]. pred_pc = pred_taken ? target[ti] : pc+1 (wraps mod 2**PC_W).
- Update (upd_valid=1, at clock edge), indices from upd_pc / upd_ghr:
  - Hit, upd_cond=1: ctr saturating +1 if taken, −1 if not (no wrap past all-ones / zero); target ← upd_target if taken.
  - Hit, upd_cond=0: ctr ← all-ones, target ← upd_target.
  - Miss, taken: allocate/overwrite: valid←1, tag, target←upd_target; ctr ← weakly taken (MSB=1, rest 0) if cond, all-ones if not.
  - Miss, not taken: no entry change.
- upd_mispredict=1 with upd_valid=1: mispredict_cnt +1, saturating at 0xFFFFFFFF. upd_mispredict ignored when upd_valid=0.
- Indirect jumps (jr/jalr) are never presented; caller holds upd_valid=0 for them.

## Timing

- Lookup zero latency: outputs follow pc and stored state in the same cycle.
- Update written at the rising edge; visible to lookups from the next cycle. Same-cycle lookup and update of the same index: lookup returns pre-update state (no bypass).
- Reset (synchronous, may assert mid-operation, overrides any concurrent update): all valid←0, all ctr←weakly not-taken (MSB=0, rest 1), GHR←0, mispredict_cnt←0. Targets/tags not cleared. During and after reset: pred_taken=0, pred_pc=pc+1, pred_ghr=0 until first update.
- No stall input; the caller gates upd_valid so each resolved instruction updates exactly once.

## Configuration

- BPRED_GHR_EN defined: GHR_W-bit global history register; ci = pc[IDX_W-1:0] XOR zero-extended GHR; pred_ghr = GHR. On every upd_valid with upd_cond=1, GHR ← {GHR[GHR_W-2:0], upd_taken}; counter update uses ci from upd_pc XOR upd_ghr. On upd_mispredict with upd_cond=1, GHR ← {upd_ghr[GHR_W-2:0], upd_taken} (repairs speculative-free history). Tags/targets still indexed by ti.
- Not defined: no history register; ci = ti; pred_ghr tied to 0; upd_ghr ignored.

## Test plan

- Reset then lookup pc=0x100: pred_taken=0, pred_pc=0x101, mispredict_cnt=0.
- Update cond, upd_pc=0x100, taken, target=0x200; next cycle pc=0x100 -> pred_taken=1, pred_pc=0x200; pc=0x140 (same index, other tag) -> pred_taken=0, pred_pc=0x141.
- Three not-taken updates at 0x100 after allocation (CTR_W=2): counter 10→01→00→00 (saturates); prediction not-taken after the first; one taken update -> 01, still not-taken; second -> 10, taken.
- Unconditional update upd_pc=0x300, target=0x010, upd_cond=0 -> lookup 0x300 taken to 0x010; one not-taken cond update keeps it taken (11→10).
- Lookup and update same index same cycle -> old prediction that cycle, new next cycle; rst asserted with concurrent upd_valid -> all entries invalid, update discarded.
- Force mispredict_cnt to 0xFFFFFFFE, two mispredict updates -> 0xFFFFFFFF held; with BPRED_GHR_EN, taken/not/taken cond updates -> pred_ghr=4'b0101.

Source files
------------

// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped branch target buffer with per-entry saturating direction counters
// and a saturating mispredict counter. Define BPRED_GHR_EN for gshare-style counter indexing.
module bpred_btb #(
    parameter int PC_W  = 30,
    parameter int IDX_W = 6,
    parameter int CTR_W = 2,
    parameter int GHR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_pc,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic             upd_cond,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_mispredict,
    output logic [31:0]      mispredict_cnt
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = ~CTR_WEAK_T;

    // Lookup is combinational, so storage is register/LUT based rather than registered-read RAM.
    logic             valid_reg  [ENTRIES];
    logic [TAG_W-1:0] tag_reg    [ENTRIES];
    logic [PC_W-1:0]  target_reg [ENTRIES];
    logic [CTR_W-1:0] ctr_reg    [ENTRIES];
    logic [31:0]      mispredict_cnt_reg;

    logic [IDX_W-1:0] ti, ci, uti, uci;
    logic [TAG_W-1:0] tag, utag;
    logic             hit, u_hit, alloc, wr_target, ctr_we;
    logic [CTR_W-1:0] ctr_next;

    assign ti   = pc[IDX_W-1:0];
    assign tag  = pc[PC_W-1:IDX_W];
    assign uti  = upd_pc[IDX_W-1:0];
    assign utag = upd_pc[PC_W-1:IDX_W];

`ifdef BPRED_GHR_EN
    logic [GHR_W-1:0] ghr_reg;
    logic [GHR_W-1:0] ghr_src;

    assign ci       = ti ^ IDX_W'(ghr_reg);
    assign uci      = uti ^ IDX_W'(upd_ghr);
    assign pred_ghr = rst ? '0 : ghr_reg;
    // A flushed branch rebuilds history from the snapshot it carried down the pipe.
    assign ghr_src  = upd_mispredict ? upd_ghr : ghr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_reg <= '0;
        end else if (upd_valid && upd_cond) begin
            ghr_reg <= GHR_W'({ghr_src, upd_taken});
        end
    end
`else
    logic unused_ghr;

    assign ci         = ti;
    assign uci        = uti;
    assign pred_ghr   = '0;
    assign unused_ghr = ^upd_ghr;
`endif

    assign hit        = valid_reg[ti] && (tag_reg[ti] == tag);
    assign pred_taken = !rst && hit && ctr_reg[ci][CTR_W-1];
    assign pred_pc    = pred_taken ? target_reg[ti] : pc + PC_W'(1);

    assign u_hit     = valid_reg[uti] && (tag_reg[uti] == utag);
    assign alloc     = upd_valid && !u_hit && upd_taken;
    assign wr_target = upd_valid && (u_hit ? (upd_taken || !upd_cond) : upd_taken);

    always_comb begin
        ctr_we   = 1'b0;
        ctr_next = ctr_reg[uci];
        if (upd_valid) begin
            if (u_hit) begin
                ctr_we = 1'b1;
                if (!upd_cond) begin
                    ctr_next = '1;
                end else if (upd_taken) begin
                    ctr_next = (ctr_reg[uci] == '1) ? ctr_reg[uci] : ctr_reg[uci] + CTR_W'(1);
                end else begin
                    ctr_next = (ctr_reg[uci] == '0) ? ctr_reg[uci] : ctr_reg[uci] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                ctr_we   = 1'b1;
                ctr_next = upd_cond ? CTR_WEAK_T : '1;
            end
        end
    end

    // Tags and targets are never cleared; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (!rst && alloc) begin
            tag_reg[uti] <= utag;
        end
        if (!rst && wr_target) begin
            target_reg[uti] <= upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
                ctr_reg[i]   <= CTR_WEAK_NT;
            end
        end else begin
            if (alloc) begin
                valid_reg[uti] <= 1'b1;
            end
            if (ctr_we) begin
                ctr_reg[uci] <= ctr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_cnt_reg <= '0;
        end else if (upd_valid && upd_mispredict && (mispredict_cnt_reg != '1)) begin
            mispredict_cnt_reg <= mispredict_cnt_reg + 32'd1;
        end
    end

    assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_bpred_btb.sv
// tb_bpred_btb: directed scenarios plus randomized traffic checked against a behavioural
// BTB model built from plain arrays and arithmetic. Honours BPRED_GHR_EN like the design.
module tb_bpred_btb;
    localparam int PC_W  = 30;
    localparam int IDX_W = 6;
    localparam int CTR_W = 2;
    localparam int GHR_W = 4;
    localparam int ENT   = 1 << IDX_W;
    localparam int CMAX  = (1 << CTR_W) - 1;
    localparam int CWT   = 1 << (CTR_W - 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PC_W-1:0]  pc = '0;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_pc;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid = 1'b0;
    logic             upd_cond = 1'b0;
    logic [PC_W-1:0]  upd_pc = '0;
    logic             upd_taken = 1'b0;
    logic [PC_W-1:0]  upd_target = '0;
    logic [GHR_W-1:0] upd_ghr = '0;
    logic             upd_mispredict = 1'b0;
    logic [31:0]      mispredict_cnt;

    bpred_btb #(.PC_W(PC_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .pred_ghr(pred_ghr), .upd_valid(upd_valid), .upd_cond(upd_cond), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model state
    bit              m_valid [ENT];
    logic [PC_W-1:0] m_tag   [ENT];
    logic [PC_W-1:0] m_tgt   [ENT];
    int              m_ctr   [ENT];
    int              m_ghr = 0;
    logic [31:0]     m_cnt = '0;

    function automatic int cidx(input logic [PC_W-1:0] p, input int h);
`ifdef BPRED_GHR_EN
        return (int'(p % ENT) ^ h) % ENT;
`else
        return int'(p % ENT) + 0 * h;
`endif
    endfunction

    function automatic logic exp_taken(input logic [PC_W-1:0] p);
        int ti = int'(p % ENT);
        if (rst) return 1'b0;
        return m_valid[ti] && (m_tag[ti] == p / ENT) && (m_ctr[cidx(p, m_ghr)] >= CWT);
    endfunction

    function automatic logic [PC_W-1:0] exp_pc(input logic [PC_W-1:0] p);
        logic [PC_W-1:0] nxt = p + 1;
        return exp_taken(p) ? m_tgt[int'(p % ENT)] : nxt;
    endfunction

    function automatic logic [GHR_W-1:0] exp_ghr();
`ifdef BPRED_GHR_EN
        return rst ? '0 : GHR_W'(m_ghr);
`else
        return '0;
`endif
    endfunction

    task automatic model_update();
        int ti, ci;
        bit hit;
        if (rst) begin
            for (int i = 0; i < ENT; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = CWT - 1;
            end
            m_ghr = 0;
            m_cnt = '0;
        end else if (upd_valid) begin
            ti  = int'(upd_pc % ENT);
            ci  = cidx(upd_pc, int'(upd_ghr));
            hit = m_valid[ti] && (m_tag[ti] == upd_pc / ENT);
            if (hit) begin
                if (!upd_cond) begin
                    m_ctr[ci] = CMAX;
                    m_tgt[ti] = upd_target;
                end else if (upd_taken) begin
                    m_ctr[ci] = (m_ctr[ci] < CMAX) ? m_ctr[ci] + 1 : CMAX;
                    m_tgt[ti] = upd_target;
                end else begin
                    m_ctr[ci] = (m_ctr[ci] > 0) ? m_ctr[ci] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[ti] = 1'b1;
                m_tag[ti]   = upd_pc / ENT;
                m_tgt[ti]   = upd_target;
                m_ctr[ci]   = upd_cond ? CWT : CMAX;
            end
            if (upd_cond)
                m_ghr = (((upd_mispredict ? int'(upd_ghr) : m_ghr) * 2) + int'(upd_taken)) % (1 << GHR_W);
            if (upd_mispredict && m_cnt != 32'hFFFF_FFFF)
                m_cnt = m_cnt + 1;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic c, input logic [PC_W-1:0] up,
                         input logic t, input logic [PC_W-1:0] tg, input logic [GHR_W-1:0] ug,
                         input logic m, input logic [PC_W-1:0] lp);
        @(negedge clk);
        rst = r; upd_valid = v; upd_cond = c; upd_pc = up; upd_taken = t;
        upd_target = tg; upd_ghr = ug; upd_mispredict = m; pc = lp;
        #1;
        $display("txn t=%0t rst=%0b upd v=%0b c=%0b pc=%h t=%0b tgt=%h g=%h m=%0b | lookup pc=%h -> taken=%0b npc=%h ghr=%h cnt=%0d",
                 $time, rst, upd_valid, upd_cond, upd_pc, upd_taken, upd_target, upd_ghr,
                 upd_mispredict, pc, pred_taken, pred_pc, pred_ghr, mispredict_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic idle(input logic [PC_W-1:0] lp);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, lp);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 30'h100);
        tick();
        idle(30'h100);
        compared++;
        if (pred_taken !== 1'b0 || pred_pc !== 30'h101) begin
            mismatched++;
            $display("FAIL reset_lookup: got taken=%0b npc=%h, want 0/101", pred_taken, pred_pc);
        end
        compared++;
        if (mispredict_cnt !== 32'd0 || pred_ghr !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got cnt=%0d ghr=%h, want 0/0", mispredict_cnt, pred_ghr);
        end
        tick();
        idle(30'h3FFF_FFFF);
        compared++;
        if (pred_taken !== 1'b0 || pred_pc !== 30'h0) begin
            mismatched++;
            $display("FAIL pc_wrap: got taken=%0b npc=%h, want 0/0", pred_taken, pred_pc);
        end
        tick();
    endtask

    task automatic test_alloc();
        logic [PC_W-1:0] looks [3] = '{30'h100, 30'h100, 30'h140};
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 1'b1, 30'h100, 1'b1, 30'h200, '0, 1'b1, looks[i]);
            else idle(looks[i]);
            compared++;
            if (pred_taken !== exp_taken(pc) || pred_pc !== exp_pc(pc)) begin
                mismatched++;
                $display("FAIL alloc_%0d pc=%h: got taken=%0b npc=%h, want %0b/%h",
                         i, pc, pred_taken, pred_pc, exp_taken(pc), exp_pc(pc));
            end
            tick();
        end
    endtask

    task automatic test_counter();
        bit tk [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b0, 1'b1, 1'b1, 30'h100, tk[i], 30'h200, pred_ghr, (i == 0), 30'h100);
            else idle(30'h100);
            compared++;
            if (pred_taken !== exp_taken(pc) || pred_pc !== exp_pc(pc)) begin
                mismatched++;
                $display("FAIL counter_%0d: got taken=%0b npc=%h, want %0b/%h",
                         i, pred_taken, pred_pc, exp_taken(pc), exp_pc(pc));
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 30'h100);
        tick();
        idle(30'h100);
        compared++;
        if (mispredict_cnt !== m_cnt) begin
            mismatched++;
            $display("FAIL mispredict_gate: got cnt=%0d, want %0d", mispredict_cnt, m_cnt);
        end
        tick();
    endtask

    task automatic test_uncond();
        drive(1'b0, 1'b1, 1'b0, 30'h300, 1'b1, 30'h010, '0, 1'b0, 30'h300);
        tick();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 1'b1, 30'h300, 1'b0, 30'h055, pred_ghr, 1'b0, 30'h300);
            else idle(30'h300);
            compared++;
            if (pred_taken !== exp_taken(pc) || pred_pc !== exp_pc(pc)) begin
                mismatched++;
                $display("FAIL uncond_%0d: got taken=%0b npc=%h, want %0b/%h",
                         i, pred_taken, pred_pc, exp_taken(pc), exp_pc(pc));
            end
            tick();
        end
    endtask

    task automatic test_reset_concurrent();
        logic [PC_W-1:0] looks [3] = '{30'h100, 30'h300, 30'h500};
        drive(1'b1, 1'b1, 1'b1, 30'h500, 1'b1, 30'h077, '0, 1'b1, 30'h100);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(looks[i]);
            compared++;
            if (pred_taken !== 1'b0 || pred_pc !== looks[i] + 30'h1 || mispredict_cnt !== 32'd0) begin
                mismatched++;
                $display("FAIL reset_override pc=%h: got taken=%0b npc=%h cnt=%0d, want 0/%h/0",
                         pc, pred_taken, pred_pc, mispredict_cnt, looks[i] + 30'h1);
            end
            tick();
        end
    endtask

    task automatic test_sat_cnt();
        @(negedge clk);
        force dut.mispredict_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.mispredict_cnt_reg;
        m_cnt = 32'hFFFF_FFFE;
        idle(30'h0);
        compared++;
        if (mispredict_cnt !== 32'hFFFF_FFFE) begin
            mismatched++;
            $display("FAIL cnt_preset: got %h, want fffffffe", mispredict_cnt);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 30'h600, 1'b1, 30'h123, '0, 1'b1, 30'h0);
            tick();
            idle(30'h0);
            compared++;
            if (mispredict_cnt !== 32'hFFFF_FFFF) begin
                mismatched++;
                $display("FAIL cnt_saturate_%0d: got %h, want ffffffff", i, mispredict_cnt);
            end
            tick();
        end
    endtask

    task automatic test_ghr();
        logic [GHR_W-1:0] want;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 30'h400, 1'b1, 30'h900, '0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 30'h401, 1'b0, 30'h900, '0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 30'h402, 1'b1, 30'h900, '0, 1'b0, '0);
        tick();
        idle('0);
`ifdef BPRED_GHR_EN
        want = 4'b0101;
`else
        want = '0;
`endif
        compared++;
        if (pred_ghr !== want) begin
            mismatched++;
            $display("FAIL ghr_shift: got %b, want %b", pred_ghr, want);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 30'h403, 1'b0, 30'h900, 4'b0011, 1'b1, '0);
        tick();
        idle('0);
`ifdef BPRED_GHR_EN
        want = 4'b0110;
`else
        want = '0;
`endif
        compared++;
        if (pred_ghr !== want) begin
            mismatched++;
            $display("FAIL ghr_repair: got %b, want %b", pred_ghr, want);
        end
        tick();
    endtask

    task automatic test_random();
        logic [PC_W-1:0] up, lp;
        logic c;
        for (int n = 0; n < 400; n++) begin
            up = PC_W'($urandom_range(0, 2) * ENT + $urandom_range(0, 7));
            lp = ($urandom_range(0, 15) == 0) ? 30'h3FFF_FFFF
                                              : PC_W'($urandom_range(0, 2) * ENT + $urandom_range(0, 7));
            c  = 1'($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0), c, up,
                  c ? 1'($urandom) : 1'b1, PC_W'($urandom), GHR_W'($urandom),
                  1'($urandom_range(0, 2) == 0), lp);
            compared++;
            if (pred_taken !== exp_taken(pc) || pred_pc !== exp_pc(pc) || pred_ghr !== exp_ghr()) begin
                mismatched++;
                $display("FAIL random_lookup_%0d pc=%h: got %0b/%h/%h, want %0b/%h/%h", n, pc,
                         pred_taken, pred_pc, pred_ghr, exp_taken(pc), exp_pc(pc), exp_ghr());
            end
            compared++;
            if (mispredict_cnt !== m_cnt) begin
                mismatched++;
                $display("FAIL random_cnt_%0d: got %0d, want %0d", n, mispredict_cnt, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_uncond();
        test_reset_concurrent();
        test_sat_cnt();
        test_ghr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
